// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU select codes and arbiter state encoding
package alu_pkg;

    localparam logic [3:0] ADD   = 4'd0;
    localparam logic [3:0] SUB   = 4'd1;
    localparam logic [3:0] SLL   = 4'd2;
    localparam logic [3:0] SLT   = 4'd3;
    localparam logic [3:0] SLTU  = 4'd4;
    localparam logic [3:0] XOR   = 4'd5;
    localparam logic [3:0] SRL   = 4'd6;
    localparam logic [3:0] SRA   = 4'd7;
    localparam logic [3:0] OR    = 4'd8;
    localparam logic [3:0] AND   = 4'd9;
    localparam logic [3:0] PASSB = 4'd10;

    localparam logic [3:0] ALU_SEL_MAX = 4'd10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } arb_state_t;

    function automatic logic sel_illegal(input logic [3:0] sel);
        return sel > ALU_SEL_MAX;
    endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational ALU datapath selected by a 4-bit ALUSel code
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [3:0]       sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] alu_out,
    output logic             a_is_zero
);

    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0] shamt;

    // Shifts use only the low log2(WIDTH) bits of b.
    assign shamt     = b[SHW-1:0];
    assign a_is_zero = (a == '0);

    always_comb begin
        alu_out = '0;
        case (sel)
            ADD:   alu_out = a + b;
            SUB:   alu_out = a - b;
            SLL:   alu_out = a << shamt;
            SLT:   alu_out = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            SLTU:  alu_out = {{(WIDTH-1){1'b0}}, (a < b)};
            XOR:   alu_out = a ^ b;
            SRL:   alu_out = a >> shamt;
            SRA:   alu_out = $unsigned($signed(a) >>> shamt);
            OR:    alu_out = a | b;
            AND:   alu_out = a & b;
            PASSB: alu_out = b;
            default: alu_out = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one ALU between two requesters
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_sel,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_data,
    output logic             rsp0_zero,
    output logic             rsp0_err,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_sel,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_data,
    output logic             rsp1_zero,
    output logic             rsp1_err,

    output logic             busy
);

    arb_state_t       state, state_nxt;
    logic             last_grant;
    logic             owner;
    logic [3:0]       op_sel;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_err;

    logic             elig0, elig1;
    logic             accept;
    logic             acc_owner;
    logic [3:0]       acc_sel;
    logic [WIDTH-1:0] acc_a, acc_b;

    logic [WIDTH-1:0] alu_out;
    logic             a_is_zero;
    logic [WIDTH-1:0] rsp_data_nxt;

    // A requester with a held response is not eligible, so its slot can never be overwritten.
    assign elig0 = req0_valid && !rsp0_valid;
    assign elig1 = req1_valid && !rsp1_valid;

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!rst) begin
                    if (elig0 && (!elig1 || last_grant)) begin
                        req0_ready = 1'b1;
                    end else if (elig1) begin
                        req1_ready = 1'b1;
                    end
                end
                if (req0_ready || req1_ready) begin
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign accept    = req0_ready || req1_ready;
    assign acc_owner = req1_ready;
    assign acc_sel   = acc_owner ? req1_sel : req0_sel;
    assign acc_a     = acc_owner ? req1_a   : req0_a;
    assign acc_b     = acc_owner ? req1_b   : req0_b;
    assign busy      = (state == ST_EXEC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            op_sel     <= '0;
            op_a       <= '0;
            op_b       <= '0;
            op_err     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                owner      <= acc_owner;
                last_grant <= acc_owner;
                // Illegal codes are parked as ADD so the ALU never sees them.
                op_sel     <= sel_illegal(acc_sel) ? ADD : acc_sel;
                op_err     <= sel_illegal(acc_sel);
                op_a       <= acc_a;
                op_b       <= acc_b;
            end
        end
    end

    alu #(
        .WIDTH (WIDTH)
    ) u_alu (
        .sel       (op_sel),
        .a         (op_a),
        .b         (op_b),
        .alu_out   (alu_out),
        .a_is_zero (a_is_zero)
    );

    assign rsp_data_nxt = op_err ? '0 : alu_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp0_valid <= 1'b0;
            rsp0_data  <= '0;
            rsp0_zero  <= 1'b0;
            rsp0_err   <= 1'b0;
        end else begin
            if (rsp0_valid && rsp0_ready) begin
                rsp0_valid <= 1'b0;
            end
            if (state == ST_EXEC && !owner) begin
                rsp0_valid <= 1'b1;
                rsp0_data  <= rsp_data_nxt;
                rsp0_zero  <= a_is_zero;
                rsp0_err   <= op_err;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp1_valid <= 1'b0;
            rsp1_data  <= '0;
            rsp1_zero  <= 1'b0;
            rsp1_err   <= 1'b0;
        end else begin
            if (rsp1_valid && rsp1_ready) begin
                rsp1_valid <= 1'b0;
            end
            if (state == ST_EXEC && owner) begin
                rsp1_valid <= 1'b1;
                rsp1_data  <= rsp_data_nxt;
                rsp1_zero  <= a_is_zero;
                rsp1_err   <= op_err;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized and directed self-checking bench for alu_arbiter
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]  req0_sel, req1_sel;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        rsp0_valid, rsp0_ready, rsp0_zero, rsp0_err;
    logic        rsp1_valid, rsp1_ready, rsp1_zero, rsp1_err;
    logic [31:0] rsp0_data, rsp1_data;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference: one in-flight slot, two held response slots, round-robin pointer.
    logic        m_inflight, m_owner, m_last;
    logic [31:0] m_res;
    logic        m_zero, m_err;
    logic        m_rv[2];
    logic [31:0] m_rd[2];
    logic        m_rz[2];
    logic        m_re[2];
    logic        g0, g1;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sel(req0_sel),
        .req0_a(req0_a), .req0_b(req0_b),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
        .rsp0_zero(rsp0_zero), .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sel(req1_sel),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
        .rsp1_zero(rsp1_zero), .rsp1_err(rsp1_err),
        .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
        logic [4:0] sh;
        sh = b[4:0];
        case (s)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a << sh;
            4'd3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd4:  return (a < b) ? 32'd1 : 32'd0;
            4'd5:  return a ^ b;
            4'd6:  return a >> sh;
            4'd7:  return 32'($signed(a) >>> sh);
            4'd8:  return a | b;
            4'd9:  return a & b;
            4'd10: return b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_inflight = 0; m_owner = 0; m_last = 1;
        m_res = 0; m_zero = 0; m_err = 0;
        for (int i = 0; i < 2; i++) begin
            m_rv[i] = 0; m_rd[i] = 0; m_rz[i] = 0; m_re[i] = 0;
        end
    endtask

    task automatic compare_all();
        logic e0, e1;
        e0 = req0_valid && !m_rv[0];
        e1 = req1_valid && !m_rv[1];
        if (rst || m_inflight) begin
            g0 = 0; g1 = 0;
        end else if (e0 && e1) begin
            g0 = m_last; g1 = !m_last;
        end else begin
            g0 = e0; g1 = e1;
        end
        check("req0_ready", req0_ready, g0);
        check("req1_ready", req1_ready, g1);
        check("busy", busy, m_inflight);
        check("rsp0_valid", rsp0_valid, m_rv[0]);
        check("rsp0_data", rsp0_data, m_rd[0]);
        check("rsp0_zero", rsp0_zero, m_rz[0]);
        check("rsp0_err", rsp0_err, m_re[0]);
        check("rsp1_valid", rsp1_valid, m_rv[1]);
        check("rsp1_data", rsp1_data, m_rd[1]);
        check("rsp1_zero", rsp1_zero, m_rz[1]);
        check("rsp1_err", rsp1_err, m_re[1]);
    endtask

    task automatic drive(input logic v0, input logic [3:0] s0, input logic [31:0] a0, input logic [31:0] b0,
                         input logic v1, input logic [3:0] s1, input logic [31:0] a1, input logic [31:0] b1,
                         input logic r0, input logic r1);
        @(negedge clk);
        req0_valid = v0; req0_sel = s0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_sel = s1; req1_a = a1; req1_b = b1;
        rsp0_ready = r0; rsp1_ready = r1;
        #1;
        compare_all();
    endtask

    task automatic idle(input logic r0, input logic r1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, r0, r1);
    endtask

    task automatic tick();
        logic [3:0]  s;
        logic [31:0] a, b;
        @(posedge clk);
        if (m_rv[0] && rsp0_ready) m_rv[0] = 0;
        if (m_rv[1] && rsp1_ready) m_rv[1] = 0;
        if (m_inflight) begin
            m_rv[m_owner] = 1; m_rd[m_owner] = m_res;
            m_rz[m_owner] = m_zero; m_re[m_owner] = m_err;
            m_inflight = 0;
        end else if (g0 || g1) begin
            m_owner = g1; m_last = g1;
            s = g1 ? req1_sel : req0_sel;
            a = g1 ? req1_a : req0_a;
            b = g1 ? req1_b : req0_b;
            m_err  = (s > 4'd10);
            m_res  = m_err ? 32'd0 : alu_ref(s, a, b);
            m_zero = (a == 32'd0);
            m_inflight = 1;
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1;
        req0_valid = 1; req1_valid = 1;
        rsp0_ready = 0; rsp1_ready = 0;
        #1;
        model_reset();
        compare_all();
        check("rst_ready0_low", req0_ready, 0);
        check("rst_busy_low", busy, 0);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 0; req1_valid = 0;
        rst = 0;
    endtask

    initial begin
        rst = 1;
        req0_valid = 0; req0_sel = 0; req0_a = 0; req0_b = 0;
        req1_valid = 0; req1_sel = 0; req1_a = 0; req1_b = 0;
        rsp0_ready = 0; rsp1_ready = 0;
        model_reset();
        apply_reset();

        // Tie from reset: req0 first, req1 two cycles later, third tie to req0.
        drive(1, 4'd1, 32'd10, 32'd3, 1, 4'd3, 32'hFFFF_FFFF, 32'd1, 0, 0);
        check("tie1_ready0", req0_ready, 1);
        tick();
        drive(1, 4'd1, 32'd10, 32'd3, 1, 4'd3, 32'hFFFF_FFFF, 32'd1, 0, 0); tick();
        drive(1, 4'd1, 32'd10, 32'd3, 1, 4'd3, 32'hFFFF_FFFF, 32'd1, 1, 0);
        check("tie_sub_data", rsp0_data, 32'd7);
        check("tie2_ready1", req1_ready, 1);
        tick();
        idle(0, 0); tick();
        idle(0, 1);
        check("tie_slt_data", rsp1_data, 32'd1);
        check("tie_slt_zero", rsp1_zero, 0);
        tick();
        drive(1, 4'd0, 32'd1, 32'd1, 1, 4'd0, 32'd2, 32'd2, 1, 1);
        check("tie3_ready0", req0_ready, 1);
        tick();
        idle(0, 0); tick();
        idle(1, 1); tick();

        // Single op: ADD 5+7, busy for exactly one cycle.
        drive(1, 4'd0, 32'd5, 32'd7, 0, 0, 0, 0, 0, 0); tick();
        idle(0, 0);
        check("single_busy", busy, 1);
        tick();
        idle(1, 0);
        check("single_valid", rsp0_valid, 1);
        check("single_data", rsp0_data, 32'd12);
        check("single_busy_done", busy, 0);
        tick();

        // Backpressure on requester 0 while requester 1 keeps being serviced.
        drive(1, 4'd9, 32'hF0, 32'h3C, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 4'd9, 32'hF0, 32'h3C, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 4'd9, 32'hF0, 32'h3C, 1, 4'd5, 32'hFF, 32'h0F, 0, 0);
        check("bp_held_data", rsp0_data, 32'h30);
        check("bp_ready0_low", req0_ready, 0);
        check("bp_ready1", req1_ready, 1);
        tick();
        drive(1, 4'd9, 32'hF0, 32'h3C, 0, 0, 0, 0, 0, 0); tick();
        drive(1, 4'd9, 32'hF0, 32'h3C, 0, 0, 0, 0, 0, 1);
        check("bp_xor_data", rsp1_data, 32'hF0);
        tick();
        drive(1, 4'd9, 32'hF0, 32'h3C, 0, 0, 0, 0, 1, 0);
        check("bp_pulse_ready0_low", req0_ready, 0);
        tick();
        drive(1, 4'd9, 32'hF0, 32'h3C, 0, 0, 0, 0, 0, 0);
        check("bp_after_ready0", req0_ready, 1);
        tick();
        idle(0, 0); tick();
        idle(1, 0); tick();

        // Illegal select on requester 1.
        drive(0, 0, 0, 0, 1, 4'd12, 32'd0, 32'd5, 0, 0); tick();
        idle(0, 0); tick();
        idle(0, 1);
        check("ill_err", rsp1_err, 1);
        check("ill_data", rsp1_data, 32'd0);
        check("ill_zero", rsp1_zero, 1);
        check("ill_busy", busy, 0);
        tick();

        // Reset while executing drops the operation.
        drive(1, 4'd7, 32'h8000_0000, 32'd4, 0, 0, 0, 0, 0, 0); tick();
        apply_reset();
        check("rstx_rsp0_valid", rsp0_valid, 0);
        drive(1, 4'd7, 32'h8000_0000, 32'd4, 1, 4'd0, 32'd1, 32'd1, 0, 0);
        check("rstx_tie_ready0", req0_ready, 1);
        tick();
        idle(0, 0); tick();
        idle(1, 0);
        check("rstx_sra_data", rsp0_data, 32'hF800_0000);
        tick();

        // Pass-through with zero a.
        drive(1, 4'd10, 32'd0, 32'h1234, 0, 0, 0, 0, 0, 0); tick();
        idle(0, 0); tick();
        idle(1, 0);
        check("passb_data", rsp0_data, 32'h1234);
        check("passb_zero", rsp0_zero, 1);
        tick();

        // Randomized traffic against the reference.
        for (int i = 0; i < 600; i++) begin
            logic [31:0] ra0, ra1;
            ra0 = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            ra1 = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), ra0, $urandom,
                  $urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), ra1, $urandom,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
            tick();
            if (i == 300) apply_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
